// File: rtl/debug_data_transmitter.sv
// Serial debug-word transmitter: a small FIFO of 40-bit words feeding a
// start-strobe / LSB-first shifter with a fixed idle gap between frames.
//
// state | meaning
// IDLE  | nothing to send, waiting for a queued word
// START | one-cycle data_start strobe, head word loaded into shifter
// SHIFT | 40 cycles, one word bit per cycle on sout, LSB first
// GAP   | GAP_CYCLES quiet cycles before the next frame or IDLE
module debug_data_transmitter #(
   parameter int GAP_CYCLES = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        debug_clk,
   input  logic        reset_n,
   input  logic [39:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        data_start,
   output logic        sout,
   output logic        busy,
   output logic [4:0]  fifo_count
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} state_t;

   state_t      state_q;
   logic [39:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [4:0]  count_q;
   logic [4:0]  count_d;
   logic [39:0] shreg_q;
   logic [5:0]  bit_cnt_q;
   logic [3:0]  gap_cnt_q;
   logic        data_start_q;
   logic        sout_q;
   logic        fifo_empty;
   logic        fifo_full;
   logic        push;
   logic        pop;

   assign fifo_empty = (count_q == 5'd0);
   assign fifo_full  = (count_q == 5'(FIFO_DEPTH));
   assign in_ready   = reset_n && !fifo_full;
   assign push       = in_valid && in_ready;
   // Pop decisions use the registered count, so a word pushed into an
   // empty FIFO is never popped on the same edge.
   assign pop        = !fifo_empty &&
                       ((state_q == IDLE) || ((state_q == GAP) && (gap_cnt_q == 4'd0)));

   always_comb begin
      count_d = count_q + {4'd0, push} - {4'd0, pop};
   end

   always_ff @(posedge debug_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   always_ff @(posedge debug_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge debug_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         data_start_q <= 1'b0;
         sout_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               data_start_q <= 1'b0;
               sout_q       <= 1'b0;
               if (pop) begin
                  state_q      <= START;
                  shreg_q      <= mem_q[rd_ptr_q];
                  data_start_q <= 1'b1;
               end
            end
            START: begin
               data_start_q <= 1'b0;
               sout_q       <= shreg_q[0];
               shreg_q      <= {1'b0, shreg_q[39:1]};
               bit_cnt_q    <= 6'd39;
               state_q      <= SHIFT;
            end
            SHIFT: begin
               if (bit_cnt_q == 6'd0) begin
                  sout_q    <= 1'b0;
                  gap_cnt_q <= 4'(GAP_CYCLES - 1);
                  state_q   <= GAP;
               end else begin
                  sout_q    <= shreg_q[0];
                  shreg_q   <= {1'b0, shreg_q[39:1]};
                  bit_cnt_q <= bit_cnt_q - 6'd1;
               end
            end
            GAP: begin
               sout_q <= 1'b0;
               if (gap_cnt_q == 4'd0) begin
                  if (pop) begin
                     state_q      <= START;
                     shreg_q      <= mem_q[rd_ptr_q];
                     data_start_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q - 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_start = data_start_q;
   assign sout       = sout_q;
   assign busy       = reset_n && ((state_q != IDLE) || !fifo_empty);
   assign fifo_count = count_q;

endmodule
